// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, waits MEM_LATENCY cycles for the
// instruction memory, and presents each instruction to decode over valid/ready.
module fetch_sequencer #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 0,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] inst_address,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  busy,
    output logic [31:0]           fetch_count
);

    // state | meaning
    // IDLE  | not fetching; waits for start
    // ISSUE | PC driven to memory; latency 0 captures here
    // WAIT  | counting down remaining memory latency
    // HOLD  | instruction valid, waiting for decode handshake
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    localparam logic [1:0] LAT_LOAD = 2'((MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0);

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [1:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic [ADDR_WIDTH-1:0]   instr_pc_q;
    logic                    valid_q;
    logic                    busy_q;
    logic [31:0]             fetch_count_q;
    logic [ADDR_WIDTH-1:0]   pc_plus1_d;
    logic                    accept_d;

    assign pc_plus1_d = pc_q + 1'b1;
    assign accept_d   = (state_q == HOLD) && valid_q && instr_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            cnt_q         <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            valid_q       <= 1'b0;
            busy_q        <= 1'b0;
            fetch_count_q <= '0;
        end else if (redirect) begin
            // An instruction accepted in the same cycle still counts before it is dropped.
            pc_q    <= redirect_pc;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            if (accept_d)
                fetch_count_q <= fetch_count_q + 32'd1;
            if (state_q == IDLE && !(start && !halt)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                state_q <= ISSUE;
                busy_q  <= 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !halt) begin
                        state_q <= ISSUE;
                        busy_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (MEM_LATENCY == 0) begin
                        instr_q    <= mem_read_data;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_plus1_d;
                        state_q    <= HOLD;
                    end else begin
                        cnt_q   <= LAT_LOAD;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt_q != 2'd0) begin
                        cnt_q <= cnt_q - 2'd1;
                    end else begin
                        instr_q    <= mem_read_data;
                        instr_pc_q <= pc_q;
                        valid_q    <= 1'b1;
                        pc_q       <= pc_plus1_d;
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept_d) begin
                        fetch_count_q <= fetch_count_q + 32'd1;
                        valid_q       <= 1'b0;
                        if (halt) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign inst_address = pc_q;
    assign instr        = instr_q;
    assign instr_pc     = instr_pc_q;
    assign instr_valid  = valid_q;
    assign busy         = busy_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the multi-cycle processor.
- Owns the program counter (PC) and drives the instruction memory's 16-bit read address.
- Waits a configurable read latency, then latches the 32-bit instruction into an instruction register.
- Presents the instruction to decode over a valid/ready handshake; supports branch/jump redirect and halt.

Parameters:
ADDR_WIDTH, 16, PC and instruction-memory address width (word index, one instruction per entry)
DATA_WIDTH, 32, instruction width
MEM_LATENCY, 0, cycles from address drive to valid read data; legal 0..3 (0 = combinational memory read)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin fetching from the current PC; sampled in IDLE only
inst_address  output  ADDR_WIDTH  address to instruction memory; always equals the PC register
mem_read_data  input  DATA_WIDTH  instruction word returned by memory
instr  output  DATA_WIDTH  latched instruction register
instr_pc  output  ADDR_WIDTH  address instr was fetched from
instr_valid  output  1  instr/instr_pc hold an unaccepted instruction
instr_ready  input  1  decode accepts instr this cycle
redirect  input  1  load new PC (branch/jump taken)
redirect_pc  input  ADDR_WIDTH  target PC for redirect
halt  input  1  level; stop after the current instruction is accepted
busy  output  1  high in any state other than IDLE
fetch_count  output  32  number of completed handshakes (instr_valid & instr_ready)

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (takes priority over everything, including mid-fetch):
  - PC = RESET_PC; state = IDLE.
  - instr = 0, instr_pc = 0, instr_valid = 0, busy = 0, fetch_count = 0.
  - Latency counter = 0; any in-flight fetch is dropped.
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - start=1 and halt=0 -> ISSUE next cycle.
  - start with halt=1 is ignored.
- ISSUE:
  - Address is already on inst_address.
  - MEM_LATENCY=0: this cycle, capture mem_read_data into instr, PC into instr_pc; set instr_valid=1 next cycle; PC <= PC+1; -> HOLD.
  - MEM_LATENCY>0: load counter = MEM_LATENCY-1; -> WAIT.
- WAIT:
  - Counter != 0: decrement and stay.
  - Counter == 0: capture as in ISSUE, PC <= PC+1, -> HOLD.
  - inst_address is held stable for the whole WAIT.
- HOLD:
  - instr_valid=1; instr and instr_pc are stable until the handshake.
  - On instr_ready: fetch_count++; instr_valid <= 0; next state is IDLE if halt=1, else ISSUE.
  - instr_ready while instr_valid=0 has no effect.
- Fetch latency: ISSUE to instr_valid is MEM_LATENCY+1 cycles. With ready tied high, throughput is one instruction per MEM_LATENCY+2 cycles.
- Redirect (evaluated after reset, before all other state actions):
  - In ISSUE/WAIT/HOLD: PC <= redirect_pc; the in-flight or held instruction is discarded (instr_valid <= 0, instr keeps its value); -> ISSUE; counter cleared.
  - If instr_ready is also high while instr_valid=1 in HOLD, that instruction counts as accepted (fetch_count++) before it is discarded.
  - Redirect with halt=1 in HOLD: redirect wins; the next fetch proceeds, and halt is honoured at its acceptance.
  - Redirect in IDLE: PC <= redirect_pc; stay IDLE.
  - Redirect with start in IDLE: PC <= redirect_pc and -> ISSUE.
- PC arithmetic: modulo 2^ADDR_WIDTH; 0xFFFF+1 -> 0x0000, no flag.
- fetch_count wraps at 2^32.
- halt asserted during ISSUE/WAIT does not abort the fetch; it takes effect at the HOLD handshake.
- busy = (state != IDLE), registered with state.

Test Plan:
- Reset, start pulse, MEM_LATENCY=0, memory[0..2]=0xA0000001/0xA0000002/0xA0000003, ready=1 -> inst_address 0,1,2; instr_valid every 2nd cycle; instr_pc 0,1,2; fetch_count=3 after 3 handshakes.
- MEM_LATENCY=2, ready held low 5 cycles after valid -> instr_valid asserts 3 cycles after ISSUE; instr stays 0xA0000001 and inst_address stays at 1 until ready; fetch_count increments exactly once.
- Redirect to 0x0040 during WAIT -> instr_valid stays 0; next instr_pc=0x0040 with memory[0x40] data; the discarded fetch is not counted.
- Redirect to 0x0010 with instr_ready=1 in the same HOLD cycle -> fetch_count++; next instr_pc=0x0010.
- redirect_pc=0xFFFF, ready=1, two fetches -> instr_pc 0xFFFF then 0x0000.
- halt=1 during WAIT -> instruction delivered, accepted, then busy=0 in IDLE. Separately, reset asserted mid-WAIT -> next cycle all outputs are at reset values and inst_address=RESET_PC.
